// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pipe
//  Description : Pipelined two's-complement adder/subtractor. A WIDTH-bit
//                operation is split into STAGES ripple-carry chunks of
//                WIDTH/STAGES bits, one chunk per stage, with the carry
//                registered between stages. Valid/ready on both sides with a
//                single global advance, so the whole pipe stalls as a unit.
//                Flags: carry out, signed overflow, zero.
//                Optional macro ADDSUB_SATURATE_EN adds a 'sat' input that
//                clamps overflowed results to the signed max/min.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe #(
   parameter int WIDTH  = 16,   // must be a multiple of STAGES
   parameter int STAGES = 4     // 1..WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef ADDSUB_SATURATE_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int               C_CW   = WIDTH / STAGES;
   localparam int               C_LAST = STAGES - 1;
   localparam logic [WIDTH-1:0] C_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Ripple chunk of full adders. Returns {carry into top bit, carry out, sum};
   // the carry into the top bit is what the overflow flag needs.
   function automatic logic [C_CW+1:0] f_ripple(input logic [C_CW-1:0] x,
                                                input logic [C_CW-1:0] y,
                                                input logic            ci);
      logic [C_CW-1:0] s;
      logic            c;
      logic            c_top;
      s     = '0;
      c     = ci;
      c_top = ci;
      for (int i = 0; i < C_CW; i++) begin
         c_top = c;
         s[i]  = x[i] ^ y[i] ^ c;
         c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c_top, c, s};
   endfunction

   // Stage registers. Element k holds what stage k produced; the last stage's
   // data lands in the dedicated output registers instead.
   logic             r_vld   [STAGES];
   logic [WIDTH-1:0] r_a     [STAGES];
   logic [WIDTH-1:0] r_b     [STAGES];
   logic [WIDTH-1:0] r_sum   [STAGES];
   logic             r_carry [STAGES];
   logic             r_sat   [STAGES];

   logic [WIDTH-1:0] r_out_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   // Per-stage inputs (from ports for stage 0, from the previous stage otherwise)
   logic             w_vld_src [STAGES];
   logic [WIDTH-1:0] w_a_src   [STAGES];
   logic [WIDTH-1:0] w_b_src   [STAGES];
   logic [WIDTH-1:0] w_sum_src [STAGES];
   logic             w_c_src   [STAGES];
   logic             w_sat_src [STAGES];

   // Per-stage chunk results
   logic [C_CW-1:0]  w_chunk   [STAGES];
   logic             w_co      [STAGES];
   logic             w_cm      [STAGES];
   logic [WIDTH-1:0] w_sum_nxt [STAGES];

   logic             w_adv;
   logic             w_raw_ovf;
   logic             w_clamp;
   logic [WIDTH-1:0] w_fin_sum;

   // Whole pipe moves when the output slot is empty or being drained
   assign w_adv    = !r_vld[C_LAST] || out_ready;
   assign in_ready = w_adv;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_first
            // Subtraction is a + ~b + ~cin; the inversion is done once up front
            assign w_vld_src[k] = in_valid;
            assign w_a_src[k]   = a;
            assign w_b_src[k]   = sub ? ~b : b;
            assign w_c_src[k]   = sub ? ~cin : cin;
            assign w_sum_src[k] = '0;
`ifdef ADDSUB_SATURATE_EN
            assign w_sat_src[k] = sat;
`else
            assign w_sat_src[k] = 1'b0;
`endif
         end else begin : g_next
            assign w_vld_src[k] = r_vld[k-1];
            assign w_a_src[k]   = r_a[k-1];
            assign w_b_src[k]   = r_b[k-1];
            assign w_c_src[k]   = r_carry[k-1];
            assign w_sum_src[k] = r_sum[k-1];
            assign w_sat_src[k] = r_sat[k-1];
         end

         assign {w_cm[k], w_co[k], w_chunk[k]} =
            f_ripple(w_a_src[k][k*C_CW +: C_CW], w_b_src[k][k*C_CW +: C_CW], w_c_src[k]);

         // Lower completed chunks ride along; this chunk's bits are still zero
         // in the incoming partial sum, so OR-ing the new chunk in is enough.
         assign w_sum_nxt[k] = w_sum_src[k] | (WIDTH'(w_chunk[k]) << (k*C_CW));
      end
   endgenerate

   // Final-stage flags and optional clamp; overflow means the true sign is the
   // opposite of the wrapped MSB.
   assign w_raw_ovf = w_cm[C_LAST] ^ w_co[C_LAST];
   assign w_clamp   = w_sat_src[C_LAST] & w_raw_ovf;
   assign w_fin_sum = w_clamp ? (w_sum_nxt[C_LAST][WIDTH-1] ? C_SMAX : C_SMIN)
                              : w_sum_nxt[C_LAST];

   // Stage valid bits and intermediate data, all shifting on the global advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_vld[i]   <= 1'b0;
            r_a[i]     <= '0;
            r_b[i]     <= '0;
            r_sum[i]   <= '0;
            r_carry[i] <= 1'b0;
            r_sat[i]   <= 1'b0;
         end
      end else if (w_adv) begin
         for (int i = 0; i < STAGES; i++) begin
            r_vld[i] <= w_vld_src[i];
         end
         for (int i = 0; i < C_LAST; i++) begin
            r_a[i]     <= w_a_src[i];
            r_b[i]     <= w_b_src[i];
            r_sum[i]   <= w_sum_nxt[i];
            r_carry[i] <= w_co[i];
            r_sat[i]   <= w_sat_src[i];
         end
      end
   end

   // Output bundle registers, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_sum <= '0;
         r_cout    <= 1'b0;
         r_ovf     <= 1'b0;
         r_zero    <= 1'b0;
      end else if (w_adv) begin
         r_out_sum <= w_fin_sum;
         r_cout    <= w_co[C_LAST];
         r_ovf     <= w_raw_ovf;
         r_zero    <= (w_fin_sum == '0);
      end
   end

   assign out_valid = r_vld[C_LAST];
   assign sum       = r_out_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_pipe
//  Description : Scoreboard bench for addsub_pipe (WIDTH=16, STAGES=4).
//                Expected results come from integer arithmetic on the
//                operands; a monitor pops and compares on every output fire.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
      int               issue;
      bit               lat;
   } exp_t;

   exp_t exp_q[$];

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             cin       = 1'b0;
   logic             sub       = 1'b0;
   logic             sat       = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   int n_cmp   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   bit rnd_rdy = 1'b0;

   addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
`ifdef ADDSUB_SATURATE_EN
      .sat       (sat),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Random consumer readiness during the soak phase
   always @(negedge clk) if (rnd_rdy) out_ready = ($urandom_range(9) < 7);

   // Reference: true integer result, then wrap / flag / clamp from it
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, input logic s, input logic st);
      exp_t        r;
      longint      ux, uy, sx, sy, c, ures, sres, hi, lo;
      logic [63:0] bits;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      c  = longint'(ci);
      hi = (longint'(1) <<< (WIDTH - 1)) - 1;
      lo = -(hi + 1);
      if (!s) begin
         ures   = ux + uy + c;
         sres   = sx + sy + c;
         r.cout = (ures >= (longint'(1) <<< WIDTH));
      end else begin
         ures   = ux - uy - c;
         sres   = sx - sy - c;
         r.cout = (ures >= 0);
      end
      r.ovf = (sres > hi) || (sres < lo);
      bits  = ures;
      r.sum = bits[WIDTH-1:0];
      if (st && r.ovf) begin
         bits  = (sres > hi) ? hi : lo;
         r.sum = bits[WIDTH-1:0];
      end
      r.zero  = (r.sum == '0);
      r.issue = 0;
      r.lat   = 1'b0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Present one bundle and wait (bounded) until it is accepted
   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s, input logic st, input bit lat);
      exp_t e;
      int   tries;
      tries = 0;
      @(negedge clk);
      a = x; b = y; cin = ci; sub = s; sat = st; in_valid = 1'b1;
      #1;
      while (!in_ready && tries < 100) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready stuck low after %0d cycles", tries);
      end else begin
`ifdef ADDSUB_SATURATE_EN
         e = model(x, y, ci, s, st);
`else
         e = model(x, y, ci, s, 1'b0);
`endif
         e.issue = cyc;
         e.lat   = lat;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // Monitor: output hold under stall, then pop/compare on each fire
   always begin : monitor
      exp_t             e;
      bit               held;
      logic [WIDTH+2:0] h_bundle;
      logic [WIDTH+2:0] now_bundle;
      held = 1'b0;
      h_bundle = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
            continue;
         end
         now_bundle = {sum, cout, ovf, zero};
         if (held) begin
            n_cmp++;
            if (!out_valid || now_bundle !== h_bundle) begin
               n_bad++;
               $display("FAIL hold: got valid=%b bundle=%h, expected valid=1 bundle=%h",
                        out_valid, now_bundle, h_bundle);
            end
         end
         held     = out_valid && !out_ready;
         h_bundle = now_bundle;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_output: got sum=%h, expected no output", sum);
            end else begin
               e = exp_q.pop_front();
               if (now_bundle !== {e.sum, e.cout, e.ovf, e.zero}) begin
                  n_bad++;
                  $display("FAIL result: got sum=%h c=%b v=%b z=%b, expected sum=%h c=%b v=%b z=%b",
                           sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
               end
               if (e.lat) begin
                  n_cmp++;
                  if (cyc - e.issue != STAGES) begin
                     n_bad++;
                     $display("FAIL latency: got %0d, expected %0d", cyc - e.issue, STAGES);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      bit last_rdy;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", WIDTH'(out_valid), '0);
      chk("rst_sum",       sum,               '0);
      chk("rst_cout",      WIDTH'(cout),      '0);
      chk("rst_ovf",       WIDTH'(ovf),       '0);
      chk("rst_zero",      WIDTH'(zero),      '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

      // Directed back-to-back, no stall, latency checked
      out_ready = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
      send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1);
      send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
      send(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
      send(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ADDSUB_SATURATE_EN
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
      idle(1);
      drain();

      // Backpressure: continuous stream with consumer stalled for 5 cycles
      last_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = 1'b0;
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         sub = 1'($urandom); sat = 1'b0; in_valid = 1'b1;
         #1;
         last_rdy = in_ready;
         if (in_ready) exp_q.push_back(model(a, b, cin, sub, 1'b0));
      end
      chk("bp_in_ready_low", WIDTH'(last_rdy),  '0);
      chk("bp_out_valid",    WIDTH'(out_valid), WIDTH'(1));
      chk("bp_accepted",     WIDTH'(exp_q.size()), WIDTH'(STAGES));
      idle(1);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++)
         send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      idle(1);
      drain();

      // Random soak with random bubbles and random backpressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) != 0)
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b0);
         else
            idle(1);
      end
      idle(1);
      rnd_rdy   = 1'b0;
      out_ready = 1'b1;
      drain();

      // Asynchronous reset with several ops in flight
      for (int i = 0; i < 5; i++)
         send(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      chk("pre_rst_valid", WIDTH'(out_valid), WIDTH'(1));
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", WIDTH'(out_valid), '0);
      chk("async_rst_sum",   sum,               '0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      drain();
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
